// File: rtl/mux81_pkg.sv
// Shared types and constants for the 8:1 mux scan sequencer.
package mux81_pkg;

    localparam int CH_N  = 8;
    localparam int SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_e;

    // Return vec with bit idx replaced by smp.
    function automatic logic [CH_N-1:0] insert_sample(
        input logic [CH_N-1:0]  vec,
        input logic [SEL_W-1:0] idx,
        input logic             smp
    );
        logic [CH_N-1:0] res;
        res      = vec;
        res[idx] = smp;
        return res;
    endfunction

endpackage

// File: rtl/mux81_dwell_timer.sv
// Dwell counter: counts enabled cycles and flags the last cycle of a dwell.
module mux81_dwell_timer #(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic last_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

    if (DWELL < 1) begin : g_bad_dwell
        $error("mux81_dwell_timer: DWELL must be at least 1");
    end

    if (((DWELL - 1) >> CNT_W) != 0) begin : g_bad_width
        $error("mux81_dwell_timer: CNT_W too narrow for DWELL");
    end

    logic [CNT_W-1:0] cnt_q;

    // Count up while enabled and wrap to zero after the last dwell cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            if (cnt_q == LAST_CNT) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign last_o = (cnt_q == LAST_CNT);

endmodule

// File: rtl/mux81_enable.sv
// 8:1 multiplexer with active-low enable; output forced low when disabled.
module mux81_enable
    import mux81_pkg::*;
(
    input  logic [CH_N-1:0]  i,
    input  logic [SEL_W-1:0] s,
    input  logic             e,
    output logic             y
);

    // Select one input when enabled, otherwise drive a quiet low.
    always_comb begin
        y = 1'b0;
        if (e) begin
            y = 1'b0;
        end else begin
            y = i[s];
        end
    end

endmodule

// File: rtl/mux81_scan_ctrl.sv
// Scan sequencer: walks the mux select 0..7, samples each channel after a
// programmable dwell and presents the eight samples as one parallel byte.
module mux81_scan_ctrl
    import mux81_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cont,
    input  logic             stop,
    input  logic             mux_y,
    output logic [SEL_W-1:0] mux_s,
    output logic             mux_e,
    output logic             busy,
    output logic             done,
    output logic [CH_N-1:0]  data
);

    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CH_N - 1);

    scan_state_e      state_q;
    logic [SEL_W-1:0] ch_q;
    logic             cont_q;
    logic [CH_N-1:0]  shadow_q;
    logic [CH_N-1:0]  data_q;
    logic             done_q;
    logic             busy_q;
    logic             mux_e_q;

    logic             tmr_clr_s;
    logic             tmr_en_s;
    logic             last_s;

    // Timer runs during SCAN and during a continuous-mode DONE cycle, which
    // is already the first cycle of the next frame's channel-0 window.
    always_comb begin
        tmr_clr_s = 1'b0;
        tmr_en_s  = 1'b0;
        if (stop) begin
            tmr_clr_s = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    tmr_clr_s = 1'b1;
                end
                SCAN: begin
                    tmr_en_s = 1'b1;
                end
                DONE: begin
                    tmr_clr_s = ~cont_q;
                    tmr_en_s  = cont_q;
                end
                default: begin
                    tmr_clr_s = 1'b1;
                end
            endcase
        end
    end

    mux81_dwell_timer #(
        .DWELL (DWELL),
        .CNT_W (CNT_W)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (tmr_clr_s),
        .en_i   (tmr_en_s),
        .last_o (last_s)
    );

    // Scan FSM with channel counter, sample shadow and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ch_q     <= '0;
            cont_q   <= 1'b0;
            shadow_q <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            mux_e_q  <= 1'b1;
        end else if (stop) begin
            // Abort: a sample due on this edge is dropped with the shadow.
            state_q  <= IDLE;
            ch_q     <= '0;
            cont_q   <= 1'b0;
            shadow_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            mux_e_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q  <= SCAN;
                        ch_q     <= '0;
                        cont_q   <= cont;
                        shadow_q <= '0;
                        busy_q   <= 1'b1;
                        mux_e_q  <= 1'b0;
                    end else begin
                        state_q  <= IDLE;
                        ch_q     <= '0;
                        busy_q   <= 1'b0;
                        mux_e_q  <= 1'b1;
                    end
                end
                SCAN: begin
                    done_q <= 1'b0;
                    if (last_s) begin
                        shadow_q <= insert_sample(shadow_q, ch_q, mux_y);
                        if (ch_q == LAST_CH) begin
                            // Frame complete: publish including the sample
                            // taken on this very edge.
                            state_q <= DONE;
                            data_q  <= insert_sample(shadow_q, ch_q, mux_y);
                            done_q  <= 1'b1;
                            ch_q    <= '0;
                            if (cont_q) begin
                                busy_q  <= 1'b1;
                                mux_e_q <= 1'b0;
                            end else begin
                                busy_q  <= 1'b0;
                                mux_e_q <= 1'b1;
                            end
                        end else begin
                            ch_q <= ch_q + SEL_W'(1);
                        end
                    end else begin
                        ch_q <= ch_q;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    if (cont_q) begin
                        state_q <= SCAN;
                        if (last_s) begin
                            // Single-cycle dwell: channel 0 finishes in DONE.
                            shadow_q <= insert_sample('0, '0, mux_y);
                            ch_q     <= SEL_W'(1);
                        end else begin
                            shadow_q <= '0;
                            ch_q     <= '0;
                        end
                    end else begin
                        state_q <= IDLE;
                        ch_q    <= '0;
                        busy_q  <= 1'b0;
                        mux_e_q <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    ch_q     <= '0;
                    cont_q   <= 1'b0;
                    shadow_q <= '0;
                    done_q   <= 1'b0;
                    busy_q   <= 1'b0;
                    mux_e_q  <= 1'b1;
                end
            endcase
        end
    end

    assign mux_s = ch_q;
    assign mux_e = mux_e_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign data  = data_q;

endmodule

// File: tb/tb_mux81_scan_ctrl.sv
// Directed bench: two sequencers (DWELL=4 and DWELL=1) each driving a mux.
module tb_mux81_scan_ctrl;

    logic       clk;
    logic       rst_n;

    logic       start4, cont4, stop4, y4, e4, busy4, done4;
    logic [2:0] s4;
    logic [7:0] i4, data4;

    logic       start1, cont1, stop1, y1, e1, busy1, done1;
    logic [2:0] s1;
    logic [7:0] i1, data1;

    int n_checks;
    int n_errors;

    mux81_scan_ctrl #(.DWELL(4), .CNT_W(8)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .cont(cont4), .stop(stop4),
        .mux_y(y4), .mux_s(s4), .mux_e(e4), .busy(busy4), .done(done4), .data(data4)
    );
    mux81_enable u_mux4 (.i(i4), .s(s4), .e(e4), .y(y4));

    mux81_scan_ctrl #(.DWELL(1), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .cont(cont1), .stop(stop1),
        .mux_y(y1), .mux_s(s1), .mux_e(e1), .busy(busy1), .done(done1), .data(data1)
    );
    mux81_enable u_mux1 (.i(i1), .s(s1), .e(e1), .y(y1));

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stimulus and checks.
    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n  = 1'b0;
        start4 = 1'b0; cont4 = 1'b0; stop4 = 1'b0; i4 = 8'h00;
        start1 = 1'b0; cont1 = 1'b0; stop1 = 1'b0; i1 = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mux_s", 32'(s4), 32'd0);
        chk("rst_mux_e", 32'(e4), 32'd1);
        chk("rst_busy",  32'(busy4), 32'd0);
        chk("rst_done",  32'(done4), 32'd0);
        chk("rst_data",  32'(data4), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single scan, DWELL=4, i=A5, with a spurious start mid-scan.
        i4 = 8'hA5; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            chk("t1_mux_s", 32'(s4), 32'((c - 1) / 4));
            chk("t1_mux_e", 32'(e4), 32'd0);
            chk("t1_busy",  32'(busy4), 32'd1);
            chk("t1_nodone", 32'(done4), 32'd0);
            if (c == 10) start4 = 1'b1;
            if (c == 11) start4 = 1'b0;
            tick();
        end
        chk("t1_done",  32'(done4), 32'd1);
        chk("t1_data",  32'(data4), 32'hA5);
        chk("t1_busy_lo", 32'(busy4), 32'd0);
        chk("t1_mux_e_hi", 32'(e4), 32'd1);
        tick();
        chk("t1_done_pulse", 32'(done4), 32'd0);
        chk("t1_data_hold", 32'(data4), 32'hA5);
        chk("t1_mux_e_after", 32'(e4), 32'd1);

        // Single scan, DWELL=1, i=3C.
        i1 = 8'h3C; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            chk("t2_mux_s", 32'(s1), 32'(c - 1));
            chk("t2_mux_e", 32'(e1), 32'd0);
            chk("t2_nodone", 32'(done1), 32'd0);
            tick();
        end
        chk("t2_done", 32'(done1), 32'd1);
        chk("t2_data", 32'(data1), 32'h3C);
        chk("t2_busy_lo", 32'(busy1), 32'd0);
        tick();
        chk("t2_done_pulse", 32'(done1), 32'd0);

        // Continuous mode, DWELL=4: 0F then F0, mux stays enabled.
        i4 = 8'h0F; cont4 = 1'b1; start4 = 1'b1;
        tick();
        start4 = 1'b0; cont4 = 1'b0;
        for (int c = 1; c <= 64; c++) begin
            chk("t3_mux_e", 32'(e4), 32'd0);
            chk("t3_busy", 32'(busy4), 32'd1);
            chk("t3_mux_s", 32'(s4), 32'(((c - 1) % 32) / 4));
            chk("t3_done", 32'(done4), 32'(c == 33));
            if (c == 33) begin
                chk("t3_data0", 32'(data4), 32'h0F);
                i4 = 8'hF0;
            end
            tick();
        end
        chk("t3_done2", 32'(done4), 32'd1);
        chk("t3_data1", 32'(data4), 32'hF0);
        chk("t3_mux_e65", 32'(e4), 32'd0);
        for (int c = 66; c <= 70; c++) begin
            tick();
            chk("t3_mux_e_run", 32'(e4), 32'd0);
        end
        stop4 = 1'b1;
        tick();
        stop4 = 1'b0;
        chk("t3_stop_busy", 32'(busy4), 32'd0);
        chk("t3_stop_mux_e", 32'(e4), 32'd1);
        chk("t3_stop_data", 32'(data4), 32'hF0);
        tick();

        // Stop at cycle 14 of a DWELL=4 scan: no done, data kept.
        i4 = 8'h5A; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int c = 1; c <= 13; c++) tick();
        chk("t4_busy_before", 32'(busy4), 32'd1);
        stop4 = 1'b1;
        tick();
        stop4 = 1'b0;
        chk("t4_busy", 32'(busy4), 32'd0);
        chk("t4_mux_e", 32'(e4), 32'd1);
        chk("t4_mux_s", 32'(s4), 32'd0);
        for (int c = 0; c < 30; c++) begin
            chk("t4_nodone", 32'(done4), 32'd0);
            chk("t4_data", 32'(data4), 32'hF0);
            tick();
        end

        // start and stop together in IDLE: no scan.
        start4 = 1'b1; stop4 = 1'b1;
        tick();
        start4 = 1'b0; stop4 = 1'b0;
        chk("t5_busy", 32'(busy4), 32'd0);
        chk("t5_mux_e", 32'(e4), 32'd1);
        repeat (3) tick();
        chk("t5_busy_later", 32'(busy4), 32'd0);

        // Async reset mid-scan, then a fresh frame.
        i4 = 8'hC3; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        repeat (8) tick();
        chk("t6_busy_pre", 32'(busy4), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_mux_s", 32'(s4), 32'd0);
        chk("t6_mux_e", 32'(e4), 32'd1);
        chk("t6_busy", 32'(busy4), 32'd0);
        chk("t6_data", 32'(data4), 32'h00);
        chk("t6_data1", 32'(data1), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            chk("t6_nodone", 32'(done4), 32'd0);
            tick();
        end
        chk("t6_done", 32'(done4), 32'd1);
        chk("t6_frame", 32'(data4), 32'hC3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
